// File: rtl/scroll_banner.sv
`default_nettype none
// ============================================================================
// Module      : scroll_banner
// Description : Scrolls a modular 0..SEQ_LEN-1 counting sequence across
//               NUM_DIGITS 4-bit digit codes (4'hF = blank). Optional macro
//               SCROLL_BANNER_BOUNCE_EN makes the banner ping-pong and
//               ignore the dir input.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_banner #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 500000,
    parameter int SEQ_LEN    = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    dir,
    input  logic                    step,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    shift_pulse
);

    localparam int                 c_TIMER_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_TIMER_W-1:0] c_TICK_LAST = c_TIMER_W'(TICK_DIV - 1);
    localparam logic [3:0]         c_SEQ_MAX   = 4'(SEQ_LEN - 1);
    localparam logic [3:0]         c_BLANK     = 4'hF;

    logic [c_TIMER_W-1:0]    r_timer;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic                    r_pulse;
    logic [3:0]              r_seq;
    logic                    r_started;

    logic                    w_tick;
    logic                    w_shift;
    logic                    w_dir;
    logic [3:0]              w_ins;
    logic [4*NUM_DIGITS-1:0] w_next_digits;

`ifdef SCROLL_BANNER_BOUNCE_EN
    logic r_dir;
    assign w_dir = r_dir;
`else
    assign w_dir = dir;
`endif

    assign w_tick  = enable && (r_timer == c_TICK_LAST);
    assign w_shift = w_tick || step;

    always_comb begin
        w_ins = 4'd0;
        if (r_started) begin
            if (w_dir) begin
                w_ins = (r_seq == c_SEQ_MAX) ? 4'd0 : r_seq + 4'd1;
            end else begin
                w_ins = (r_seq == 4'd0) ? c_SEQ_MAX : r_seq - 4'd1;
            end
        end
    end

    // Forward pushes the new value in at digit 0; reverse at the top digit.
    assign w_next_digits = w_dir ? {r_digits[4*NUM_DIGITS-5:0], w_ins}
                                 : {w_ins, r_digits[4*NUM_DIGITS-1:4]};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_timer   <= '0;
            r_digits  <= {NUM_DIGITS{c_BLANK}};
            r_pulse   <= 1'b0;
            r_seq     <= 4'd0;
            r_started <= 1'b0;
`ifdef SCROLL_BANNER_BOUNCE_EN
            r_dir     <= 1'b1;
`endif
        end else begin
            if (enable) begin
                r_timer <= w_tick ? '0 : r_timer + 1'b1;
            end
            r_pulse <= w_shift;
            if (w_shift) begin
                r_digits  <= w_next_digits;
                r_seq     <= w_ins;
                r_started <= 1'b1;
`ifdef SCROLL_BANNER_BOUNCE_EN
                // Turn around on reaching either end; the very first insert never counts.
                if (r_started && ((r_dir && w_ins == c_SEQ_MAX) || (!r_dir && w_ins == 4'd0))) begin
                    r_dir <= ~r_dir;
                end
`endif
            end
        end
    end

    assign digits      = r_digits;
    assign shift_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_scroll_banner.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_banner
// Description : Self-checking bench for scroll_banner (4 digits, tick every 4
//               enabled cycles, modulus 10) with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_banner;

    localparam int c_ND  = 4;
    localparam int c_TD  = 4;
    localparam int c_SL  = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              dir = 1'b1;
    logic              step = 1'b0;
    logic              clear = 1'b0;
    logic [4*c_ND-1:0] digits;
    logic              shift_pulse;

    int n_checks = 0;
    int n_errors = 0;

    scroll_banner #(.NUM_DIGITS(c_ND), .TICK_DIV(c_TD), .SEQ_LEN(c_SL)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dir        (dir),
        .step       (step),
        .clear      (clear),
        .digits     (digits),
        .shift_pulse(shift_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model: digit list, enabled-cycle count, last inserted value.
    int m_dig[c_ND];
    int m_cnt;
    int m_seq;
    bit m_started;
    bit m_dirreg;
    bit m_pulse;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*c_ND-1:0] model_digits();
        logic [4*c_ND-1:0] p;
        for (int i = 0; i < c_ND; i++) p[4*i +: 4] = 4'(m_dig[i]);
        return p;
    endfunction

    always @(posedge clk) begin
        bit tick, sh, d;
        int v;
        if (reset || clear) begin
            for (int i = 0; i < c_ND; i++) m_dig[i] = 15;
            m_cnt = 0; m_seq = 0; m_started = 0; m_pulse = 0; m_dirreg = 1;
            if (reset) m_valid = 1'b1;
        end else begin
            tick = enable && (m_cnt == c_TD - 1);
            if (enable) m_cnt = (m_cnt + 1) % c_TD;
            sh = tick || step;
            m_pulse = sh;
            if (sh) begin
`ifdef SCROLL_BANNER_BOUNCE_EN
                d = m_dirreg;
`else
                d = dir;
`endif
                if (!m_started) v = 0;
                else if (d)     v = (m_seq + 1) % c_SL;
                else            v = (m_seq + c_SL - 1) % c_SL;
                if (m_started && ((d && v == c_SL - 1) || (!d && v == 0))) m_dirreg = ~m_dirreg;
                m_started = 1; m_seq = v;
                if (d) begin
                    for (int i = c_ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                    m_dig[0] = v;
                end else begin
                    for (int i = 0; i < c_ND - 1; i++) m_dig[i] = m_dig[i+1];
                    m_dig[c_ND-1] = v;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_digits", 32'(digits), 32'(model_digits()));
            chk("model_pulse", 32'(shift_pulse), 32'(m_pulse));
        end
    end

    // Waits (bounded) for the next shift_pulse; returns negedges elapsed.
    task automatic wait_pulse(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (shift_pulse === 1'b1) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_pulse: got no pulse expected pulse within 40 cycles");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; step = 1'b0; clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_digits", 32'(digits), 32'h0000_FFFF);
        chk("reset_pulse", 32'(shift_pulse), 32'd0);
        reset = 1'b0;
    endtask

    logic [15:0] fwd_exp [10];
    logic [15:0] rev_exp [4];
    int n;

    initial begin
        fwd_exp = '{16'hFFF0, 16'hFF01, 16'hF012, 16'h0123, 16'h1234,
                    16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789};
        rev_exp = '{16'h0FFF, 16'h90FF, 16'h890F, 16'h7890};

`ifndef SCROLL_BANNER_BOUNCE_EN
        // Forward fill, including the 9->0 wrap.
        do_reset();
        enable = 1'b1; dir = 1'b1;
        for (int k = 0; k < 11; k++) begin
            wait_pulse(n);
            chk("fwd_period", 32'(n), 32'd4);
            chk("fwd_digits", 32'(digits), (k < 10) ? 32'(fwd_exp[k]) : 32'h7890);
        end

        // Reverse fill.
        do_reset();
        enable = 1'b1; dir = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(n);
            chk("rev_digits", 32'(digits), 32'(rev_exp[k]));
        end
`endif

        // Pause: timer freezes with enable low.
        do_reset();
        dir = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("pause_hold", 32'(digits), 32'h0000_FFFF);
        enable = 1'b1;
        wait_pulse(n);
        chk("pause_resume_delay", 32'(n), 32'd2);
        chk("pause_resume_digits", 32'(digits), 32'h0000_FFF0);

        // Manual step with the timer frozen.
        do_reset();
        dir = 1'b1; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step_digits", 32'(digits), 32'h0000_FFF0);
        chk("step_pulse", 32'(shift_pulse), 32'd1);
        @(negedge clk);
        chk("step_single", 32'(shift_pulse), 32'd0);

        // Clear coincident with a tick at 0123, then the same with reset.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            enable = 1'b1; dir = 1'b1;
            repeat (4) wait_pulse(n);
            chk("pre_clear", 32'(digits), 32'h0000_0123);
            repeat (3) @(negedge clk);
            if (r == 0) clear = 1'b1; else reset = 1'b1;
            @(negedge clk);
            clear = 1'b0; reset = 1'b0;
            chk("clear_digits", 32'(digits), 32'h0000_FFFF);
            chk("clear_pulse", 32'(shift_pulse), 32'd0);
            wait_pulse(n);
            chk("clear_restart_delay", 32'(n), 32'd4);
            chk("clear_restart_digits", 32'(digits), 32'h0000_FFF0);
        end

        // Randomized run checked cycle-by-cycle against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 9) < 8);
            dir    = ($urandom_range(0, 19) != 0) ? dir : ~dir;
            step   = ($urandom_range(0, 9) < 2);
            clear  = ($urandom_range(0, 199) == 0);
            reset  = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        reset = 1'b0; clear = 1'b0; step = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
